// File: rtl/snake_pkg.sv
// Shared snake design types: game mode encoding and on-screen button geometry.
package snake_pkg;

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        COUNTDOWN = 3'd1,
        GAME      = 3'd2,
        WIN       = 3'd3,
        LOSE      = 3'd4,
        DRAW      = 3'd5,
        ERROR     = 3'd6
    } game_mode;

    // All buttons share one column; rows are disjoint so END and REMATCH never overlap.
    localparam int BUTTONS_X   = 200;
    localparam int BUTTONS_W   = 240;
    localparam int BUTTONS_H   = 60;
    localparam int BUTTON2_Y   = 200;
    localparam int BUTTONEND_Y = 300;
    localparam int BUTTONREM_Y = 400;
    localparam int BUTTONE_Y   = 500;

endpackage

// File: rtl/button_hit.sv
// Rectangular hit test of a click against one button region [X, X+W) x [Y, Y+H).
module button_hit #(
    parameter int X       = 0,
    parameter int Y       = 0,
    parameter int W       = 1,
    parameter int H       = 1,
    parameter int COORD_W = 12
) (
    input  logic               click,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               hit
);

    // One extra bit so X+W / Y+H cannot wrap at the top of the coordinate range.
    localparam logic [COORD_W:0] X_LO = (COORD_W+1)'(X);
    localparam logic [COORD_W:0] X_HI = (COORD_W+1)'(X + W);
    localparam logic [COORD_W:0] Y_LO = (COORD_W+1)'(Y);
    localparam logic [COORD_W:0] Y_HI = (COORD_W+1)'(Y + H);

    logic [COORD_W:0] x_ext;
    logic [COORD_W:0] y_ext;

    assign x_ext = {1'b0, x};
    assign y_ext = {1'b0, y};
    assign hit   = click && (x_ext >= X_LO) && (x_ext < X_HI)
                         && (y_ext >= Y_LO) && (y_ext < Y_HI);

endmodule

// File: rtl/game_mode_fsm.sv
// Top-level snake game mode sequencer with countdown, rematch and click hit-testing.
// Optional GAME_MODE_ERR_TIMEOUT_EN: ERROR returns to MENU after ERR_TIMEOUT_S seconds.
//
// state     | meaning
// MENU      | idle, waiting for local START click or remote start
// COUNTDOWN | pre-game seconds countdown, tick_1s running
// GAME      | game in progress, waiting for a result or link error
// WIN/LOSE/DRAW | result screen, END / REMATCH / remote restart
// ERROR     | link error screen, tick_1s running, exit via ERRBTN
module game_mode_fsm
    import snake_pkg::*;
#(
    parameter int CLK_HZ        = 75_000_000,
    parameter int COUNTDOWN_S   = 3,
    parameter int ERR_TIMEOUT_S = 10,
    parameter int COORD_W       = 12
) (
    input  logic               clk_75,
    input  logic               rst_n,
    input  logic               start_game,
    input  logic               won,
    input  logic               lost,
    input  logic               draw,
    input  logic               con_error,
    input  logic [COORD_W-1:0] click_x,
    input  logic [COORD_W-1:0] click_y,
    input  logic               click_e,
    output game_mode           mode,
    output logic               local_start,
    output logic [3:0]         countdown,
    output logic               tick_1s
);

    localparam int              PW        = $clog2(CLK_HZ);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [3:0]      CD_INIT   = 4'(COUNTDOWN_S);

    logic [PW-1:0] presc;
    logic          click_q;
    logic          click;
    logic          wrap;
    logic          timeout;
    logic          hit_start;
    logic          hit_end;
    logic          hit_rem;
    logic          hit_err;

    assign click = click_e & ~click_q;
    assign wrap  = (presc == PRESC_MAX);

    button_hit #(.X(BUTTONS_X), .Y(BUTTON2_Y), .W(BUTTONS_W), .H(BUTTONS_H), .COORD_W(COORD_W))
        u_hit_start (.click(click), .x(click_x), .y(click_y), .hit(hit_start));
    button_hit #(.X(BUTTONS_X), .Y(BUTTONEND_Y), .W(BUTTONS_W), .H(BUTTONS_H), .COORD_W(COORD_W))
        u_hit_end (.click(click), .x(click_x), .y(click_y), .hit(hit_end));
    button_hit #(.X(BUTTONS_X), .Y(BUTTONREM_Y), .W(BUTTONS_W), .H(BUTTONS_H), .COORD_W(COORD_W))
        u_hit_rem (.click(click), .x(click_x), .y(click_y), .hit(hit_rem));
    button_hit #(.X(BUTTONS_X), .Y(BUTTONE_Y), .W(BUTTONS_W), .H(BUTTONS_H), .COORD_W(COORD_W))
        u_hit_err (.click(click), .x(click_x), .y(click_y), .hit(hit_err));

`ifdef GAME_MODE_ERR_TIMEOUT_EN
    localparam int            EW       = $clog2(ERR_TIMEOUT_S + 1);
    localparam logic [EW-1:0] ERR_INIT = EW'(ERR_TIMEOUT_S);

    logic [EW-1:0] err_cnt;

    // Held at the reload value outside ERROR, so every ERROR visit starts a full timeout.
    always_ff @(posedge clk_75 or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= ERR_INIT;
        else if (mode != ERROR)
            err_cnt <= ERR_INIT;
        else if (wrap)
            err_cnt <= err_cnt - EW'(1);
    end

    assign timeout = (mode == ERROR) && wrap && (err_cnt == EW'(1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_75 or negedge rst_n) begin
        if (!rst_n) begin
            mode        <= MENU;
            local_start <= 1'b0;
            countdown   <= 4'd0;
            tick_1s     <= 1'b0;
            presc       <= '0;
            click_q     <= 1'b0;
        end else begin
            click_q <= click_e;
            tick_1s <= 1'b0;
            presc   <= '0;
            case (mode)
                MENU: begin
                    countdown <= 4'd0;
                    if (hit_start) begin
                        mode        <= COUNTDOWN;
                        local_start <= 1'b1;
                        countdown   <= CD_INIT;
                    end else if (start_game) begin
                        mode        <= COUNTDOWN;
                        local_start <= 1'b0;
                        countdown   <= CD_INIT;
                    end
                end
                COUNTDOWN: begin
                    if (con_error) begin
                        mode      <= ERROR;
                        countdown <= 4'd0;
                    end else if (wrap) begin
                        tick_1s <= 1'b1;
                        if (countdown == 4'd1) begin
                            mode      <= GAME;
                            countdown <= 4'd0;
                        end else begin
                            countdown <= countdown - 4'd1;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                GAME: begin
                    if (con_error)  mode <= ERROR;
                    else if (won)   mode <= WIN;
                    else if (lost)  mode <= LOSE;
                    else if (draw)  mode <= DRAW;
                end
                WIN, LOSE, DRAW: begin
                    if (hit_end) begin
                        mode        <= MENU;
                        local_start <= 1'b0;
                    end else if (hit_rem) begin
                        mode        <= COUNTDOWN;
                        local_start <= 1'b1;
                        countdown   <= CD_INIT;
                    end else if (start_game) begin
                        mode        <= COUNTDOWN;
                        local_start <= 1'b0;
                        countdown   <= CD_INIT;
                    end
                end
                ERROR: begin
                    if (wrap)
                        tick_1s <= 1'b1;
                    else
                        presc <= presc + PW'(1);
                    if (hit_err || timeout) begin
                        mode        <= MENU;
                        local_start <= 1'b0;
                        presc       <= '0;
                    end
                end
                default: begin
                    mode        <= MENU;
                    local_start <= 1'b0;
                    countdown   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/game_mode_fsm.md
Name: game_mode_fsm

Overview:
Next-generation top-level game mode controller for the snake design. It sequences MENU -> COUNTDOWN -> GAME -> result -> MENU/rematch and hit-tests mouse clicks against parametrised button regions. It adds a pre-game countdown, rematch, click edge detection and an optional error auto-return. It sits between the mouse/UART link blocks and the draw/game-logic blocks; its mode output drives the renderer and game core.

Parameters:
CLK_HZ, 75_000_000, clock frequency; sets the 1 s tick prescaler
COUNTDOWN_S, 3, countdown length in seconds (1..15)
ERR_TIMEOUT_S, 10, seconds spent in ERROR before auto-return (only with the optional feature)
COORD_W, 12, width of click coordinates

Ports:
clk_75  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
start_game  in  1  remote player started the game (level, sampled each cycle)
won  in  1  game result: local win
lost  in  1  game result: local loss
draw  in  1  game result: draw
con_error  in  1  link error
click_x  in  COORD_W  mouse x
click_y  in  COORD_W  mouse y
click_e  in  1  mouse button (level)
mode  out  game_mode  current state
local_start  out  1  local player initiated the current session
countdown  out  4  seconds remaining; valid in COUNTDOWN, else 0
tick_1s  out  1  one-cycle pulse every second while in COUNTDOWN or ERROR

Behaviour:
- Reset (async assert, sync release): mode=MENU, local_start=0, countdown=0, tick_1s=0, prescaler=0, click edge register=0.
- Click edge detection: click = click_e & ~click_e_q. A held button fires once only.
- Hits: hit_X = click and (X_X <= click_x < X_X+X_W) and (X_Y <= click_y < X_Y+X_H). Bounds come from package constants. Compare at COORD_W+1 bits so sums cannot wrap.
- All outputs are registered. A state change is visible 1 cycle after the qualifying input.
- MENU:
  - hit START -> COUNTDOWN, local_start=1.
  - else start_game -> COUNTDOWN, local_start=0. A local click takes priority if both occur in the same cycle.
  - On entry to COUNTDOWN: countdown=COUNTDOWN_S, prescaler=0.
- COUNTDOWN:
  - Prescaler counts 0..CLK_HZ-1. At wrap: tick_1s pulses and countdown decrements.
  - When countdown==1 at wrap -> GAME and countdown=0.
  - con_error -> ERROR immediately; this has priority over the tick.
- GAME: priority con_error > won > lost > draw -> ERROR/WIN/LOSE/DRAW. local_start holds its value.
- WIN/LOSE/DRAW:
  - hit END -> MENU, local_start=0.
  - hit REMATCH -> COUNTDOWN, local_start=1.
  - else start_game -> COUNTDOWN, local_start=0.
  - END/REMATCH regions never overlap. If they did, END wins.
- ERROR:
  - hit ERRBTN -> MENU, local_start=0.
  - start_game is ignored.
  - Prescaler restarts on entry.
- Illegal encoding -> MENU, local_start=0.
- Reset mid-COUNTDOWN or mid-GAME returns to MENU asynchronously. No partial count is retained.
- Prescaler width is $clog2(CLK_HZ). The seconds counter is 4 bits.

Optional Feature:
GAME_MODE_ERR_TIMEOUT_EN
- Defined: ERROR also returns to MENU after ERR_TIMEOUT_S tick_1s pulses. Timeout and an ERRBTN click in the same cycle give MENU, with no conflict. con_error still asserted at the timeout does not re-enter ERROR until mode is GAME again.
- Undefined: ERROR exits only on an ERRBTN click. tick_1s still pulses in ERROR. No seconds counter logic is instantiated for ERROR.

Decomposition:
- snake_pkg gets the game_mode enum extended with COUNTDOWN (MENU, COUNTDOWN, GAME, WIN, LOSE, DRAW, ERROR).
- snake_pkg also gets the button constants: BUTTONS_X, BUTTONS_W, BUTTONS_H, BUTTON2_Y (START), BUTTONEND_Y (END), BUTTONREM_Y (REMATCH), BUTTONE_Y (ERRBTN).
- Sub-module button_hit (params X, Y, W, H, COORD_W; inputs click, x, y; output hit) is instantiated four times.
- The prescaler and seconds counter stay inline.

Test Plan:
All scenarios use CLK_HZ=10, COUNTDOWN_S=3, ERR_TIMEOUT_S=2.
- Reset then local start: rst_n low mid-run, then release; click inside START with click_e held 5 cycles -> mode=MENU, then COUNTDOWN once, local_start=1, countdown=3.
- Countdown timing: from entry, countdown 3->2->1 at cycles 10 and 20; mode=GAME at cycle 30 with countdown=0; exactly 3 tick_1s pulses.
- Result priority: in GAME, assert con_error, won and draw in the same cycle -> ERROR. Separately, won and lost together -> WIN.
- Rematch and remote restart: in LOSE, click REMATCH -> COUNTDOWN, local_start=1. In DRAW, assert start_game without a click -> COUNTDOWN, local_start=0. In WIN, click START coordinates -> mode unchanged.
- Mid-countdown error: con_error at countdown=2 -> ERROR next cycle; click ERRBTN -> MENU, local_start=0.
- Feature on: stay in ERROR with no click -> MENU after 20 cycles. Feature off: still ERROR after 100 cycles.
